// File: rtl/sxr_cam_tag_array.sv
// Parametrised CAM tag array: per-entry valid bits, invalidate/flush, a registered
// search returning match bits and the lowest hit index, and a fill/round-robin allocator.
module sxr_cam_tag_array #(
  parameter int TAG_W = 8,
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_n,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             alloc_n,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             inv_n,
  input  logic [IDX_W-1:0] inv_idx,
  input  logic             flush_n,
  input  logic             srch_n,
  input  logic [TAG_W-1:0] argin,
  output logic             srch_done,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic [DEPTH-1:0] mbits,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [TAG_W-1:0] dout,
  output logic             dout_vld,
  output logic [IDX_W-1:0] victim_idx,
  output logic             full
);

  logic [DEPTH-1:0][TAG_W-1:0] tag_r;
  logic [DEPTH-1:0]            vld_r;
  logic [IDX_W-1:0]            rr_ptr_r;

  logic [DEPTH-1:0][TAG_W-1:0] tag_nxt_s;
  logic [DEPTH-1:0]            vld_nxt_s;
  logic [IDX_W-1:0]            rr_nxt_s;
  logic [DEPTH-1:0]            match_s;
  logic [IDX_W-1:0]            victim_s;
  logic                        full_s;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [DEPTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Allocator victim, occupancy and per-entry match against the pre-edge array.
  always_comb begin
    full_s   = &vld_r;
    victim_s = full_s ? rr_ptr_r : lowest_set(~vld_r);
    match_s  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = vld_r[i] && (tag_r[i] == argin);
    end
  end

  // Array update with priority flush > invalidate > allocate > directed write.
  always_comb begin
    tag_nxt_s = tag_r;
    vld_nxt_s = vld_r;
    rr_nxt_s  = rr_ptr_r;
    if (!flush_n) begin
      vld_nxt_s = '0;
      rr_nxt_s  = '0;
    end else begin
      if (!alloc_n) begin
        // An invalidate aimed at the victim wins; the allocate is dropped and the pointer holds.
        if (inv_n || (inv_idx != victim_s)) begin
          tag_nxt_s[victim_s] = wr_tag;
          vld_nxt_s[victim_s] = 1'b1;
          rr_nxt_s            = full_s ? (rr_ptr_r + IDX_W'(1)) : rr_ptr_r;
        end else begin
          rr_nxt_s = rr_ptr_r;
        end
      end else if (!wr_n) begin
        if (inv_n || (inv_idx != wr_idx)) begin
          tag_nxt_s[wr_idx] = wr_tag;
          vld_nxt_s[wr_idx] = 1'b1;
        end else begin
          rr_nxt_s = rr_ptr_r;
        end
      end else begin
        rr_nxt_s = rr_ptr_r;
      end
      if (!inv_n) begin
        vld_nxt_s[inv_idx] = 1'b0;
      end else begin
        rr_nxt_s = rr_nxt_s;
      end
    end
  end

  // Storage and allocator pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r    <= '0;
      vld_r    <= '0;
      rr_ptr_r <= '0;
    end else begin
      tag_r    <= tag_nxt_s;
      vld_r    <= vld_nxt_s;
      rr_ptr_r <= rr_nxt_s;
    end
  end

  // Search result register: results hold until the next search, done pulses once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srch_done <= 1'b0;
      hit       <= 1'b0;
      hit_idx   <= '0;
      mbits     <= '0;
    end else if (!srch_n) begin
      srch_done <= 1'b1;
      hit       <= |match_s;
      hit_idx   <= lowest_set(match_s);
      mbits     <= match_s;
    end else begin
      srch_done <= 1'b0;
    end
  end

  assign dout       = tag_r[rd_idx];
  assign dout_vld   = vld_r[rd_idx];
  assign victim_idx = victim_s;
  assign full       = full_s;

endmodule

// File: tb/tb_sxr_cam_tag_array.sv
// Directed bench for sxr_cam_tag_array: expected search results queued at issue,
// popped and compared when srch_done is observed.
module tb_sxr_cam_tag_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_n = 1'b1;
  logic [1:0] wr_idx = 2'd0;
  logic       alloc_n = 1'b1;
  logic [7:0] wr_tag = 8'h00;
  logic       inv_n = 1'b1;
  logic [1:0] inv_idx = 2'd0;
  logic       flush_n = 1'b1;
  logic       srch_n = 1'b1;
  logic [7:0] argin = 8'h00;
  logic       srch_done;
  logic       hit;
  logic [1:0] hit_idx;
  logic [3:0] mbits;
  logic [1:0] rd_idx = 2'd0;
  logic [7:0] dout;
  logic       dout_vld;
  logic [1:0] victim_idx;
  logic       full;

  int total = 0;
  int bad = 0;
  logic [6:0] exp_q[$];

  sxr_cam_tag_array #(.TAG_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .wr_idx(wr_idx), .alloc_n(alloc_n),
    .wr_tag(wr_tag), .inv_n(inv_n), .inv_idx(inv_idx), .flush_n(flush_n),
    .srch_n(srch_n), .argin(argin), .srch_done(srch_done), .hit(hit),
    .hit_idx(hit_idx), .mbits(mbits), .rd_idx(rd_idx), .dout(dout),
    .dout_vld(dout_vld), .victim_idx(victim_idx), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one search edge (srch_n left low for back-to-back use) and score its result.
  task automatic srch(input string name, input logic [7:0] arg,
                      input logic e_hit, input logic [1:0] e_idx, input logic [3:0] e_mb);
    logic [6:0] e;
    srch_n = 1'b0;
    argin  = arg;
    exp_q.push_back({e_hit, e_idx, e_mb});
    cyc();
    chk({name, "_done"}, {31'd0, srch_done}, 32'd1);
    if (srch_done === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({name, "_hit"},   {31'd0, hit},     {31'd0, e[6]});
      chk({name, "_idx"},   {30'd0, hit_idx}, {30'd0, e[5:4]});
      chk({name, "_mbits"}, {28'd0, mbits},   {28'd0, e[3:0]});
    end else begin
      chk({name, "_pending"}, {31'd0, srch_done}, 32'd1);
    end
  endtask

  task automatic rd(input string name, input logic [1:0] idx, input logic v, input logic [7:0] t);
    rd_idx = idx;
    #1;
    chk({name, "_vld"}, {31'd0, dout_vld}, {31'd0, v});
    if (v) chk({name, "_tag"}, {24'd0, dout}, {24'd0, t});
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_done",   {31'd0, srch_done},  32'd0);
    chk("rst_hit",    {31'd0, hit},        32'd0);
    chk("rst_idx",    {30'd0, hit_idx},    32'd0);
    chk("rst_mbits",  {28'd0, mbits},      32'd0);
    chk("rst_full",   {31'd0, full},       32'd0);
    chk("rst_victim", {30'd0, victim_idx}, 32'd0);
    rd("rst_rd0", 2'd0, 1'b0, 8'h00);

    srch("s_zero", 8'h00, 1'b0, 2'd0, 4'b0000);
    srch_n = 1'b1;
    cyc();
    chk("done_pulse", {31'd0, srch_done}, 32'd0);
    chk("hold_mbits", {28'd0, mbits}, 32'd0);

    alloc_n = 1'b0;
    wr_tag = 8'hA1; cyc();
    chk("victim_after1", {30'd0, victim_idx}, 32'd1);
    wr_tag = 8'hA2; cyc();
    wr_tag = 8'hA3; cyc();
    wr_tag = 8'hA4; cyc();
    alloc_n = 1'b1;
    chk("full_4", {31'd0, full}, 32'd1);
    chk("victim_full", {30'd0, victim_idx}, 32'd0);
    rd("rd3", 2'd3, 1'b1, 8'hA4);

    alloc_n = 1'b0;
    wr_tag = 8'hB5; cyc();
    wr_tag = 8'hB6; cyc();
    alloc_n = 1'b1;
    chk("victim_rr", {30'd0, victim_idx}, 32'd2);
    rd("rd0_b5", 2'd0, 1'b1, 8'hB5);
    rd("rd1_b6", 2'd1, 1'b1, 8'hB6);

    srch("s_a1", 8'hA1, 1'b0, 2'd0, 4'b0000);
    srch("s_b6", 8'hB6, 1'b1, 2'd1, 4'b0010);
    srch_n = 1'b1;

    wr_n = 1'b0; wr_tag = 8'h33;
    wr_idx = 2'd1; cyc();
    wr_idx = 2'd3; cyc();
    wr_n = 1'b1;
    srch("s_33a", 8'h33, 1'b1, 2'd1, 4'b1010);
    srch_n = 1'b1;

    inv_n = 1'b0; inv_idx = 2'd1; cyc();
    inv_n = 1'b1;
    rd("inv_keeps_tag", 2'd1, 1'b0, 8'h33);
    chk("inv_tag_retained", {24'd0, dout}, 32'h33);
    srch("s_33b", 8'h33, 1'b1, 2'd3, 4'b1000);
    srch_n = 1'b1;
    chk("victim_inv", {30'd0, victim_idx}, 32'd1);
    chk("full_inv", {31'd0, full}, 32'd0);

    inv_n = 1'b0; inv_idx = 2'd3; flush_n = 1'b0;
    srch("s_pre_flush", 8'h33, 1'b1, 2'd3, 4'b1000);
    inv_n = 1'b1; flush_n = 1'b1;
    srch("s_post_flush", 8'h33, 1'b0, 2'd0, 4'b0000);
    srch_n = 1'b1;
    chk("full_flush", {31'd0, full}, 32'd0);
    chk("victim_flush", {30'd0, victim_idx}, 32'd0);

    // Allocate and directed write on one edge: the directed write is dropped.
    alloc_n = 1'b0; wr_n = 1'b0; wr_idx = 2'd2; wr_tag = 8'h55; cyc();
    alloc_n = 1'b1; wr_n = 1'b1;
    rd("alloc_wins", 2'd0, 1'b1, 8'h55);
    rd("wr_dropped", 2'd2, 1'b0, 8'h00);
    srch("s_b2b_1", 8'h55, 1'b1, 2'd0, 4'b0001);
    srch("s_b2b_2", 8'h77, 1'b0, 2'd0, 4'b0000);
    srch("s_b2b_3", 8'h55, 1'b1, 2'd0, 4'b0001);
    srch_n = 1'b1;

    // Reset while a search result is being presented, held across an edge.
    srch_n = 1'b0; argin = 8'h55;
    @(posedge clk);
    #1;
    srch_n = 1'b1;
    chk("pre_rst_hit", {31'd0, hit}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_done",  {31'd0, srch_done}, 32'd0);
    chk("arst_hit",   {31'd0, hit},       32'd0);
    chk("arst_mbits", {28'd0, mbits},     32'd0);
    srch_n = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_no_pulse", {31'd0, srch_done}, 32'd0);
    rd("arst_vld", 2'd0, 1'b0, 8'h00);
    srch_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_done", {31'd0, srch_done}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
